// File: rtl/common_memory_reader_if.sv
// ---------------------------------------------------------------------------
// common_memory_reader_if
// Bundles the request, memory and consumer-handshake signals of the common
// memory reader. Signal names are the reader's port names.
//   slave  : the reader itself (takes request, drives memory strobe/address,
//            presents the read word)
//   master : the surrounding system (CPU datapath, memory, consumer)
// Signals:
//   ireq/iaddr            read request and address from the datapath
//   obusy                 reader not idle
//   omem_addr/omem_re     address and one-cycle read strobe to memory
//   imem_data/imem_valid  memory response
//   odata/ovalid/iready   captured word and its valid/ready handshake
//   oerr                  one-cycle timeout pulse
// ---------------------------------------------------------------------------
interface common_memory_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  ireq;
  logic [ADDR_WIDTH-1:0] iaddr;
  logic                  obusy;
  logic [ADDR_WIDTH-1:0] omem_addr;
  logic                  omem_re;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  imem_valid;
  logic [DATA_WIDTH-1:0] odata;
  logic                  ovalid;
  logic                  iready;
  logic                  oerr;

  modport slave (
    input  ireq, iaddr, imem_data, imem_valid, iready,
    output obusy, omem_addr, omem_re, odata, ovalid, oerr
  );

  modport master (
    output ireq, iaddr, imem_data, imem_valid, iready,
    input  obusy, omem_addr, omem_re, odata, ovalid, oerr
  );
endinterface

// File: rtl/common_memory_reader.sv
// ---------------------------------------------------------------------------
// common_memory_reader
// Read-side controller for the shared common memory. Accepts one read request
// at a time, pulses the memory read strobe for one cycle, waits (bounded by
// TIMEOUT cycles) for the memory's data-valid, then holds the returned word
// under a valid/ready handshake until the consumer takes it.
// Ports:
//   iclk    clock, rising edge
//   irst_n  asynchronous active-low reset
//   bus     common_memory_reader_if.slave (request, memory, consumer signals)
// All outputs come straight from flops or from a decode of the state flops;
// no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module common_memory_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15   // legal range 1..255
) (
  input  logic                    iclk,
  input  logic                    irst_n,
  common_memory_reader_if.slave   bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  err_q,   err_d;

  always_comb begin
    // NOTE: every signal gets its default before the case, so no branch can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ireq) begin
          addr_d  = bus.iaddr;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Data wins over the timeout when both land on the same edge.
        if (bus.imem_valid) begin
          data_d  = bus.imem_data;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (bus.iready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop updates from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Strobe, valid and busy are pure decodes of the state register, so they
  // drop together with it when reset is asserted.
  assign bus.obusy     = (state_q != S_IDLE);
  assign bus.omem_re   = (state_q == S_REQ);
  assign bus.ovalid    = (state_q == S_HOLD);
  assign bus.omem_addr = addr_q;
  assign bus.odata     = data_q;
  assign bus.oerr      = err_q;

endmodule

// File: tb/tb_common_memory_reader.sv
// ---------------------------------------------------------------------------
// tb_common_memory_reader
// Directed bench for common_memory_reader. Stimulus pushes the expected
// outcome of each transaction (word or timeout) into a scoreboard queue; a
// monitor pops and compares whenever a word transfers or oerr pulses.
// ---------------------------------------------------------------------------
module tb_common_memory_reader;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 15;

  typedef struct packed {
    logic          is_err;
    logic [DW-1:0] data;
  } exp_t;

  logic iclk   = 1'b0;
  logic irst_n = 1'b1;
  always #5 iclk = ~iclk;

  common_memory_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  common_memory_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .bus    (bus.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  int   re_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic is_err, input logic [DW-1:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    return e;
  endfunction

  // Memory contents: 0x3C holds 0x1234, every other address holds {A5, addr}.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 8'h3C) return 16'h1234;
    return {8'hA5, a};
  endfunction

  // Memory model: automatic mode answers one cycle after the read strobe;
  // manual mode lets the stimulus drive valid/data directly.
  logic          mem_auto   = 1'b1;
  logic          auto_valid = 1'b0;
  logic          man_valid  = 1'b0;
  logic          prev_re    = 1'b0;
  logic [DW-1:0] auto_data  = '0;
  logic [DW-1:0] man_data   = '0;

  assign bus.imem_valid = mem_auto ? auto_valid : man_valid;
  assign bus.imem_data  = mem_auto ? auto_data  : man_data;

  initial begin
    forever begin
      @(posedge iclk);
      #1;
      auto_valid = prev_re;
      auto_data  = prev_re ? mem_word(bus.omem_addr) : 16'h0000;
      prev_re    = bus.omem_re;
    end
  end

  // Strobe pulse counter.
  initial begin
    forever begin
      @(negedge iclk);
      if (bus.omem_re === 1'b1) re_count++;
    end
  end

  // Scoreboard monitor: a word transfers on the next edge when ovalid and
  // iready are both high; a timeout shows as oerr.
  initial begin
    exp_t e;
    forever begin
      @(negedge iclk);
      if (irst_n === 1'b1 && bus.ovalid === 1'b1 && bus.iready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_word", 32'(bus.odata), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("sb_word_not_err", 32'd0, 32'(e.is_err));
          check("sb_word_data", 32'(bus.odata), 32'(e.data));
        end
      end
      if (irst_n === 1'b1 && bus.oerr === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_err", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_timeout_expected", 32'd1, 32'(e.is_err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    bus.ireq  = 1'b1;
    bus.iaddr = a;
    tick();
    bus.ireq  = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge iclk);
    irst_n = 1'b1;
    tick();
  endtask

  // Watchdog: the stimulus has no open-ended waits, this only guards a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            re_start;
    logic [DW-1:0] b2b_exp [4];
    b2b_exp[0] = 16'hA500;
    b2b_exp[1] = 16'hA501;
    b2b_exp[2] = 16'hA502;
    b2b_exp[3] = 16'hA503;

    bus.ireq   = 1'b0;
    bus.iaddr  = '0;
    bus.iready = 1'b1;

    // ---------------- reset values ----------------
    #2 irst_n = 1'b0;
    #1;
    check("rst_obusy",     32'(bus.obusy),     32'd0);
    check("rst_omem_re",   32'(bus.omem_re),   32'd0);
    check("rst_omem_addr", 32'(bus.omem_addr), 32'd0);
    check("rst_odata",     32'(bus.odata),     32'd0);
    check("rst_ovalid",    32'(bus.ovalid),    32'd0);
    check("rst_oerr",      32'(bus.oerr),      32'd0);
    release_reset();

    // ---------------- basic read, iready high ----------------
    re_start = re_count;
    sb_q.push_back(mk(1'b0, 16'h1234));
    issue(8'h3C);
    check("basic_re_after_E0",   32'(bus.omem_re),   32'd1);
    check("basic_addr",          32'(bus.omem_addr), 32'h3C);
    check("basic_busy_after_E0", 32'(bus.obusy),     32'd1);
    tick();
    check("basic_re_after_E1",     32'(bus.omem_re), 32'd0);
    check("basic_ovalid_after_E1", 32'(bus.ovalid),  32'd0);
    tick();
    check("basic_ovalid_after_E2", 32'(bus.ovalid), 32'd1);
    check("basic_odata",           32'(bus.odata),  32'h1234);
    tick();
    check("basic_ovalid_after_xfer", 32'(bus.ovalid), 32'd0);
    check("basic_busy_after_xfer",   32'(bus.obusy),  32'd0);
    check("basic_re_pulses",         32'(re_count - re_start), 32'd1);

    // ---------------- consumer stalls 5 cycles, ireq in HOLD ignored ----------------
    re_start   = re_count;
    bus.iready = 1'b0;
    sb_q.push_back(mk(1'b0, 16'h1234));
    issue(8'h3C);
    tick();
    tick();
    bus.ireq  = 1'b1;
    bus.iaddr = 8'h10;
    for (int i = 0; i < 5; i++) begin
      check("hold_ovalid", 32'(bus.ovalid),    32'd1);
      check("hold_odata",  32'(bus.odata),     32'h1234);
      check("hold_no_re",  32'(bus.omem_re),   32'd0);
      check("hold_addr",   32'(bus.omem_addr), 32'h3C);
      tick();
    end
    bus.ireq   = 1'b0;
    bus.iready = 1'b1;
    tick();
    check("hold_ovalid_after_xfer", 32'(bus.ovalid),    32'd0);
    check("hold_addr_after_xfer",   32'(bus.omem_addr), 32'h3C);
    check("hold_re_pulses",         32'(re_count - re_start), 32'd1);

    // ---------------- timeout: memory never answers ----------------
    mem_auto  = 1'b0;
    man_valid = 1'b0;
    man_data  = 16'h0000;
    sb_q.push_back(mk(1'b1, 16'h0000));
    issue(8'h20);
    tick();                                   // now in WAIT
    for (int k = 1; k <= TO; k++) begin
      tick();
      check("timeout_oerr_timing", 32'(bus.oerr),  32'(k == TO));
      check("timeout_busy",        32'(bus.obusy), 32'(k != TO));
    end
    check("timeout_ovalid", 32'(bus.ovalid), 32'd0);
    check("timeout_odata",  32'(bus.odata),  32'h1234);
    tick();
    check("timeout_oerr_one_cycle", 32'(bus.oerr),      32'd0);
    check("timeout_addr_kept",      32'(bus.omem_addr), 32'h20);

    // ---------------- stray valids, then data on the timeout edge ----------------
    man_valid = 1'b1;
    man_data  = 16'hDEAD;
    tick();
    check("stray_idle_ovalid", 32'(bus.ovalid), 32'd0);
    check("stray_idle_busy",   32'(bus.obusy),  32'd0);
    sb_q.push_back(mk(1'b0, 16'hBEEF));
    issue(8'h21);                             // valid high in IDLE and REQ
    check("bound_re", 32'(bus.omem_re), 32'd1);
    tick();
    check("stray_req_ovalid", 32'(bus.ovalid), 32'd0);
    man_valid = 1'b0;
    repeat (TO - 1) tick();
    man_valid = 1'b1;
    man_data  = 16'hBEEF;
    tick();
    check("bound_ovalid", 32'(bus.ovalid), 32'd1);
    check("bound_odata",  32'(bus.odata),  32'hBEEF);
    check("bound_oerr",   32'(bus.oerr),   32'd0);
    man_valid = 1'b0;
    tick();
    check("bound_ovalid_after_xfer", 32'(bus.ovalid), 32'd0);
    check("bound_oerr_after_xfer",   32'(bus.oerr),   32'd0);

    // ---------------- four back-to-back reads ----------------
    mem_auto   = 1'b1;
    bus.iready = 1'b1;
    re_start   = re_count;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(mk(1'b0, b2b_exp[i]));
      issue(AW'(i));                           // sampled at edge 4*i
      check("b2b_addr", 32'(bus.omem_addr), 32'(i));
      tick();
      tick();
      check("b2b_ovalid", 32'(bus.ovalid), 32'd1);
      check("b2b_odata",  32'(bus.odata),  32'(b2b_exp[i]));
      tick();
      check("b2b_idle", 32'(bus.obusy), 32'd0);
    end
    tick();
    check("b2b_re_pulses", 32'(re_count - re_start), 32'd4);

    // ---------------- reset in REQ, WAIT and HOLD ----------------
    mem_auto  = 1'b0;
    man_valid = 1'b0;
    issue(8'h05);
    #2 irst_n = 1'b0;
    #1;
    check("rst_req_omem_re", 32'(bus.omem_re), 32'd0);
    check("rst_req_busy",    32'(bus.obusy),   32'd0);
    release_reset();

    issue(8'h06);
    tick();
    tick();                                   // in WAIT
    #2 irst_n = 1'b0;
    #1;
    check("rst_wait_busy",   32'(bus.obusy),     32'd0);
    check("rst_wait_re",     32'(bus.omem_re),   32'd0);
    check("rst_wait_ovalid", 32'(bus.ovalid),    32'd0);
    check("rst_wait_oerr",   32'(bus.oerr),      32'd0);
    check("rst_wait_addr",   32'(bus.omem_addr), 32'd0);
    release_reset();

    mem_auto   = 1'b1;
    bus.iready = 1'b0;
    issue(8'h3C);
    tick();
    tick();                                   // in HOLD, word never taken
    check("pre_rst_hold_ovalid", 32'(bus.ovalid), 32'd1);
    #2 irst_n = 1'b0;
    #1;
    check("rst_hold_ovalid", 32'(bus.ovalid), 32'd0);
    check("rst_hold_odata",  32'(bus.odata),  32'd0);
    bus.iready = 1'b1;
    release_reset();

    // Recovery read after reset.
    sb_q.push_back(mk(1'b0, 16'h1234));
    issue(8'h3C);
    check("recover_re", 32'(bus.omem_re), 32'd1);
    tick();
    tick();
    check("recover_ovalid", 32'(bus.ovalid), 32'd1);
    check("recover_odata",  32'(bus.odata),  32'h1234);
    tick();
    check("recover_idle", 32'(bus.obusy), 32'd0);
    tick();

    check("sb_all_consumed", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
